l1_l2_arbiter: RTL and testbench

- Shares the single L2 cache port between the L1 instruction cache and the L1 data cache inside cpu_cache_toplevel.
- Captures the winning request into registers, drives the L2 port from those registers, and routes the L2 response back to the granted requester.
- A watchdog flags any L2 transaction that exceeds a cycle limit.

---
 rtl/l1_l2_arbiter_pkg.sv | 26 ++
 rtl/l1_l2_arbiter_if.sv | 26 ++
 rtl/l1_l2_arbiter_watchdog.sv | 39 +++
 rtl/l1_l2_arbiter.sv | 112 +++++++++++
 tb/tb_l1_l2_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_l2_arbiter_pkg.sv
// rtl/l1_l2_arbiter_pkg.sv - shared types and defaults for the L1/L2 port arbiter
package arb_types_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // A lone requester always wins; 'favour' only breaks a tie.
  function automatic grant_t pick_grant(logic i_pend, logic d_pend, grant_t favour);
    if (i_pend && d_pend) begin
      return favour;
    end
    return d_pend ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// rtl/l1_l2_arbiter_if.sv - cache memory port: master issues read/write, slave returns rdata/resp
interface l1_l2_arbiter_if
  import arb_types_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (
    output read, write, address, wdata,
    input  rdata, resp
  );

  modport slave (
    input  read, write, address, wdata,
    output rdata, resp
  );

endinterface

// File: rtl/l1_l2_arbiter_watchdog.sv
// rtl/l1_l2_arbiter_watchdog.sv - saturating busy-cycle counter with sticky timeout flag
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic timeout_err
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_q;

  always_comb begin
    count_d = '0;
    if (busy) begin
      count_d = (count_q == LIMIT) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (count_d == LIMIT) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = err_q;

endmodule

// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - shares one L2 port between icache and dcache; dcache priority by default,
// alternating tie-break when ARB_ROUND_ROBIN_EN is defined.
module l1_l2_arbiter
  import arb_types_pkg::*;
#(
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int LINE_W         = ARB_LINE_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  l1_l2_arbiter_if.slave   i_mem,
  l1_l2_arbiter_if.slave   d_mem,
  l1_l2_arbiter_if.master  l2,
  output logic             timeout_err
);

  arb_state_t        state_q;
  logic              l2_read_q;
  logic              l2_write_q;
  logic [ADDR_W-1:0] l2_address_q;
  logic [LINE_W-1:0] l2_wdata_q;

  logic   i_pend;
  logic   d_pend;
  grant_t favour;
  grant_t winner;

  assign i_pend = i_mem.read | i_mem.write;
  assign d_pend = d_mem.read | d_mem.write;
  assign winner = pick_grant(i_pend, d_pend, favour);

`ifdef ARB_ROUND_ROBIN_EN
  // Holds the requester owed the next tie; starting at I means I wins the first tie after reset.
  grant_t favour_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favour_q <= GNT_I;
    end else if (state_q == IDLE && (i_pend || d_pend)) begin
      favour_q <= (winner == GNT_I) ? GNT_D : GNT_I;
    end
  end

  assign favour = favour_q;
`else
  assign favour = GNT_D;
`endif

  // Requester inputs are only looked at in IDLE, so a transaction in flight cannot be disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_pend || d_pend) begin
            if (winner == GNT_D) begin
              state_q      <= SERVE_D;
              l2_write_q   <= d_mem.write;
              l2_read_q    <= d_mem.read & ~d_mem.write;
              l2_address_q <= d_mem.address;
              l2_wdata_q   <= d_mem.wdata;
            end else begin
              state_q      <= SERVE_I;
              l2_write_q   <= i_mem.write;
              l2_read_q    <= i_mem.read & ~i_mem.write;
              l2_address_q <= i_mem.address;
              l2_wdata_q   <= i_mem.wdata;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2.resp) begin
            state_q    <= IDLE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          l2_read_q  <= 1'b0;
          l2_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign l2.read    = l2_read_q;
  assign l2.write   = l2_write_q;
  assign l2.address = l2_address_q;
  assign l2.wdata   = l2_wdata_q;

  assign i_mem.resp  = (state_q == SERVE_I) & l2.resp;
  assign d_mem.resp  = (state_q == SERVE_D) & l2.resp;
  assign i_mem.rdata = l2.rdata;
  assign d_mem.rdata = l2.rdata;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (state_q != IDLE),
    .timeout_err (timeout_err)
  );

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb/tb_l1_l2_arbiter.sv - randomized and directed checks of l1_l2_arbiter against a transaction model
module tb_l1_l2_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic timeout_err;

  always #5 clk = ~clk;

  l1_l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) i_bus ();
  l1_l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) d_bus ();
  l1_l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) l2_bus ();

  l1_l2_arbiter #(
    .ADDR_W         (AW),
    .LINE_W         (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem       (i_bus),
    .d_mem       (d_bus),
    .l2          (l2_bus),
    .timeout_err (timeout_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction model: who owns the L2 port (0 none, 1 icache, 2 dcache) and what was captured.
  int          m_owner;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [255:0] m_wdata;
  int          m_serve;
  bit          m_err;
  int          m_fav;
  bit          seen_i;
  bit          seen_d;
  int          l2_lat = -1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_line();
    return $urandom() & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) begin
      v[k*32 +: 32] = $urandom();
    end
    return v;
  endfunction

  task automatic zero_inputs();
    i_bus.read = 0; i_bus.write = 0; i_bus.address = '0; i_bus.wdata = '0;
    d_bus.read = 0; d_bus.write = 0; d_bus.address = '0; d_bus.wdata = '0;
    l2_bus.resp = 0; l2_bus.rdata = '0;
  endtask

  task automatic model_reset();
    m_owner = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    m_serve = 0; m_err = 0; m_fav = 1; seen_i = 0; seen_d = 0; l2_lat = -1;
  endtask

  // Called at the falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    bit ir, dr, pi, pd;
    int win;
    #1;
    ir = (m_owner == 1) && l2_bus.resp;
    dr = (m_owner == 2) && l2_bus.resp;
    check("i_resp", i_bus.resp, ir);
    check("d_resp", d_bus.resp, dr);
    check("i_rdata", i_bus.rdata, l2_bus.rdata);
    check("d_rdata", d_bus.rdata, l2_bus.rdata);
    seen_i = ir;
    seen_d = dr;
    if (m_owner == 0) begin
      m_serve = 0;
      pi = i_bus.read | i_bus.write;
      pd = d_bus.read | d_bus.write;
      if (pi || pd) begin
        if (pi && pd) win = RR ? m_fav : 2;
        else          win = pd ? 2 : 1;
        m_fav   = (win == 1) ? 2 : 1;
        m_owner = win;
        m_wr    = (win == 2) ? d_bus.write   : i_bus.write;
        m_addr  = (win == 2) ? d_bus.address : i_bus.address;
        m_wdata = (win == 2) ? d_bus.wdata   : i_bus.wdata;
      end
    end else begin
      m_serve = (m_serve < TO) ? m_serve + 1 : TO;
      if (m_serve >= TO) m_err = 1;
      if (l2_bus.resp) m_owner = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check("l2_read", l2_bus.read, (m_owner != 0) && !m_wr);
    check("l2_write", l2_bus.write, (m_owner != 0) && m_wr);
    check("l2_address", l2_bus.address, m_addr);
    check("l2_wdata", l2_bus.wdata, m_wdata);
    check("timeout_err", timeout_err, m_err);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #1;
    check("rst_l2_read", l2_bus.read, 0);
    check("rst_l2_write", l2_bus.write, 0);
    check("rst_i_resp", i_bus.resp, 0);
    check("rst_d_resp", d_bus.resp, 0);
    zero_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_l2_address", l2_bus.address, 0);
    check("rst_l2_wdata", l2_bus.wdata, 0);
    check("rst_timeout", timeout_err, 0);
  endtask

  task automatic rand_cycle(input bit gen);
    int op;
    if (seen_i || !gen) begin
      i_bus.read = 0; i_bus.write = 0;
    end else if (!(i_bus.read || i_bus.write)) begin
      if ($urandom_range(2) == 0) begin
        i_bus.read = 1; i_bus.write = ($urandom_range(7) == 0);
        i_bus.address = rand_line(); i_bus.wdata = rand_data();
      end
    end else if ($urandom_range(3) == 0) begin
      i_bus.address = rand_line();
    end
    if (seen_d || !gen) begin
      d_bus.read = 0; d_bus.write = 0;
    end else if (!(d_bus.read || d_bus.write)) begin
      if ($urandom_range(2) == 0) begin
        op = $urandom_range(2);
        d_bus.read = (op != 1); d_bus.write = (op != 0);
        d_bus.address = rand_line(); d_bus.wdata = rand_data();
      end
    end else if ($urandom_range(3) == 0) begin
      d_bus.address = rand_line();
      d_bus.wdata = rand_data();
    end
    if (m_owner != 0) begin
      if (l2_lat < 0) l2_lat = $urandom_range(4);
      l2_bus.resp = (l2_lat == 0);
      l2_lat = l2_bus.resp ? -1 : l2_lat - 1;
    end else begin
      l2_bus.resp = ($urandom_range(7) == 0);
      l2_lat = -1;
    end
    l2_bus.rdata = rand_data();
    tick();
  endtask

  initial begin
    logic [255:0] rd;
    rst_n = 1;
    zero_inputs();
    model_reset();
    #2;
    apply_reset();

    // Lone icache read
    i_bus.read = 1; i_bus.address = 32'h0000_04c0;
    tick();
    check("lone_l2_read", l2_bus.read, 1);
    check("lone_l2_addr", l2_bus.address, 32'h4c0);
    tick();
    tick();
    rd = rand_data();
    l2_bus.resp = 1; l2_bus.rdata = rd;
    #1;
    check("lone_i_resp", i_bus.resp, 1);
    check("lone_i_rdata", i_bus.rdata, rd);
    check("lone_d_resp", d_bus.resp, 0);
    tick();
    l2_bus.resp = 0; i_bus.read = 0;
    tick();

    // Simultaneous requests
    i_bus.read = 1; i_bus.address = 32'h100;
    d_bus.write = 1; d_bus.address = 32'h200; d_bus.wdata = '1;
    tick();
    check("sim_first_addr", l2_bus.address, RR ? 32'h100 : 32'h200);
    check("sim_first_write", l2_bus.write, RR ? 0 : 1);
    l2_bus.resp = 1;
    tick();
    l2_bus.resp = 0;
    if (RR) i_bus.read = 0; else d_bus.write = 0;
    check("sim_bubble_rd", l2_bus.read, 0);
    check("sim_bubble_wr", l2_bus.write, 0);
    tick();
    check("sim_second_addr", l2_bus.address, RR ? 32'h200 : 32'h100);
    check("sim_second_read", l2_bus.read, RR ? 0 : 1);
    l2_bus.resp = 1;
    tick();
    l2_bus.resp = 0; i_bus.read = 0; d_bus.write = 0;
    tick();

    // Capture stability
    d_bus.read = 1; d_bus.address = 32'h340;
    tick();
    d_bus.address = 32'hFFFF_FFE0;
    tick();
    check("cap_addr_a", l2_bus.address, 32'h340);
    tick();
    check("cap_addr_b", l2_bus.address, 32'h340);
    l2_bus.resp = 1;
    tick();
    l2_bus.resp = 0; d_bus.read = 0;
    tick();

    // Read+write from the same requester
    d_bus.read = 1; d_bus.write = 1; d_bus.address = 32'h80;
    tick();
    check("rw_write", l2_bus.write, 1);
    check("rw_read", l2_bus.read, 0);
    l2_bus.resp = 1;
    tick();
    l2_bus.resp = 0; d_bus.read = 0; d_bus.write = 0;
    tick();

    // Reset mid-transaction, with the L2 answering as reset hits
    i_bus.read = 1; i_bus.address = 32'h1c0;
    tick();
    check("mid_l2_read", l2_bus.read, 1);
    l2_bus.resp = 1;
    apply_reset();
    tick();
    check("post_rst_idle", l2_bus.read, 0);

    // Randomized traffic, then drain
    for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
    for (int c = 0; c < 10; c++) rand_cycle(1'b0);
    zero_inputs();
    tick();
    check("drain_idle", l2_bus.read | l2_bus.write, 0);

    // Watchdog: hold off the L2 response for 20 cycles
    d_bus.read = 1; d_bus.address = 32'h600;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == TO - 1) check("wd_before", timeout_err, 0);
      if (k == TO)     check("wd_set", timeout_err, 1);
    end
    l2_bus.resp = 1;
    tick();
    l2_bus.resp = 0; d_bus.read = 0;
    tick();
    tick();
    check("wd_sticky", timeout_err, 1);
    check("wd_idle", l2_bus.read, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
